// File: rtl/ahb_lite_cmd_master_if.sv
// Command-port and AHB-Lite bus bundle for ahb_lite_cmd_master.
// The master modport is the DUT side; the slave modport is the command source plus memory slave side.
interface ahb_lite_cmd_master_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_error;
   logic                  rsp_timeout;
   logic                  HSEL;
   logic [ADDR_WIDTH-1:0] HADDR;
   logic [1:0]            HTRANS;
   logic                  HWRITE;
   logic [DATA_WIDTH-1:0] HWDATA;
   logic [DATA_WIDTH-1:0] HRDATA;
   logic                  HREADY;
   logic                  HRESP;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
             HSEL, HADDR, HTRANS, HWRITE, HWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
             HSEL, HADDR, HTRANS, HWRITE, HWDATA
   );
endinterface

// File: rtl/ahb_lite_cmd_master.sv
// Single-outstanding AHB-Lite master turning valid/ready commands into NONSEQ single transfers.
// Optional HREADY-low watchdog enabled by defining AHB_MST_TIMEOUT_EN.
module ahb_lite_cmd_master #(
   parameter int ADDR_WIDTH     = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   ahb_lite_cmd_master_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   if (TIMEOUT_CYCLES < 1) begin : g_badTimeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t                r_state;
   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_err;
   logic                  r_rspValid;
   logic [DATA_WIDTH-1:0] r_rspRdata;
   logic                  r_rspError;
   logic                  r_rspTimeout;

   state_t                w_nextState;
   logic                  w_write;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic                  w_err;
   logic                  w_rspValid;
   logic [DATA_WIDTH-1:0] w_rspRdata;
   logic                  w_rspError;
   logic                  w_rspTimeout;
   logic                  w_timeout;

`ifdef AHB_MST_TIMEOUT_EN
   localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] r_waitCnt;

   // Counts consecutive HREADY-low cycles; IDLE and any HREADY=1 restart it, so each phase starts at zero.
   always_ff @(posedge HCLK) begin
      if (HRESET || (r_state == IDLE) || bus.HREADY) begin
         r_waitCnt <= '0;
      end else begin
         r_waitCnt <= r_waitCnt + 1'b1;
      end
   end

   assign w_timeout = (r_state != IDLE) && !bus.HREADY && (r_waitCnt == CntLast);
`else
   assign w_timeout = 1'b0;
`endif

   // Next-state and next-register values; a timeout abort overrides normal phase progress.
   always_comb begin
      w_nextState  = r_state;
      w_write      = r_write;
      w_addr       = r_addr;
      w_wdata      = r_wdata;
      w_err        = r_err;
      w_rspValid   = 1'b0;
      w_rspRdata   = r_rspRdata;
      w_rspError   = r_rspError;
      w_rspTimeout = r_rspTimeout;

      if (w_timeout) begin
         w_nextState  = IDLE;
         w_err        = 1'b0;
         w_rspValid   = 1'b1;
         w_rspRdata   = '0;
         w_rspError   = 1'b1;
         w_rspTimeout = 1'b1;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  w_nextState = ADDR;
                  w_write     = bus.cmd_write;
                  w_addr      = bus.cmd_addr;
                  w_err       = 1'b0;
                  if (bus.cmd_write) begin
                     w_wdata = bus.cmd_wdata;
                  end
               end
            end
            ADDR: begin
               if (bus.HREADY) begin
                  w_nextState = DATA;
               end
            end
            DATA: begin
               if (bus.HREADY) begin
                  w_nextState  = IDLE;
                  w_err        = 1'b0;
                  w_rspValid   = 1'b1;
                  w_rspRdata   = r_write ? '0 : bus.HRDATA;
                  w_rspError   = r_err | bus.HRESP;
                  w_rspTimeout = 1'b0;
               end else if (bus.HRESP) begin
                  w_err = 1'b1;
               end
            end
            default: begin
               w_nextState = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers; reset drops any in-flight command without a response.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_state      <= IDLE;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_err        <= 1'b0;
         r_rspValid   <= 1'b0;
         r_rspRdata   <= '0;
         r_rspError   <= 1'b0;
         r_rspTimeout <= 1'b0;
      end else begin
         r_state      <= w_nextState;
         r_write      <= w_write;
         r_addr       <= w_addr;
         r_wdata      <= w_wdata;
         r_err        <= w_err;
         r_rspValid   <= w_rspValid;
         r_rspRdata   <= w_rspRdata;
         r_rspError   <= w_rspError;
         r_rspTimeout <= w_rspTimeout;
      end
   end

   assign bus.cmd_ready   = (r_state == IDLE);
   assign bus.HSEL        = (r_state != IDLE);
   assign bus.HTRANS      = (r_state == ADDR) ? 2'b10 : 2'b00;
   assign bus.HADDR       = r_addr;
   assign bus.HWRITE      = r_write;
   assign bus.HWDATA      = r_wdata;
   assign bus.rsp_valid   = r_rspValid;
   assign bus.rsp_rdata   = r_rspRdata;
   assign bus.rsp_error   = r_rspError;
   assign bus.rsp_timeout = r_rspTimeout;

endmodule
